data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Sequencer between the memory-stage request port and data_memory. Accepts one load/store/swap
//  request at a time, checks alignment, and drives address, byte-lane write enables, swap control
//  and load/store mux selects. SWP/SWPB run as an atomic read-then-write pair. Returns load/swap
//  read data with the destination tag and stalls the pipeline while a request is in flight.
// PARAMETERS
//  TAG_W   4   width of destination-register tag carried with each request
// PORTS
//  clk_in            in   1    clock; all state updates on rising edge
//  reset_in          in   1    asynchronous, active-high reset
//  req_valid_in      in   1    request present
//  req_ready_out     out  1    controller idle; request accepted when valid&ready
//  req_op_in         in   4    0 LDR,1 LDRH,2 LDRSH,3 LDRB,4 LDRSB,5 STR,6 STRH,7 STRB,8 SWP,9 SWPB
//  req_addr_in       in   32   byte address
//  req_wdata_in      in   32   store/swap data (sub-word data in low bits)
//  req_tag_in        in   TAG_W destination tag (loads/swaps)
//  mem_addr_out      out  32   address to data_memory
//  mem_we_out        out  4    byte-lane write enables to data_memory
//  mem_wd_out        out  32   write data to data_memory
//  mem_swp_ctrl_out  out  1    forces all four lanes written (word SWP only)
//  mem_load_sel_out  out  3    load mux select: 0 word,1 zext half,2 sext half,3 zext byte,4 sext byte
//  mem_str_sel_out   out  3    store mux select, same encoding (0 word,1 half,3 byte)
//  mem_rd_in         in   32   read data from data_memory, valid one cycle after address
//  rsp_valid_out     out  1    one-cycle pulse: rsp_rdata_out/rsp_tag_out valid
//  rsp_rdata_out     out  32   load result / SWP old memory value
//  rsp_tag_out       out  TAG_W tag of completed request
//  st_done_out       out  1    one-cycle pulse: store written
//  abort_out         out  1    one-cycle pulse: misaligned or illegal op, no memory access
//  stall_out         out  1    high whenever state != IDLE
// BEHAVIOUR
//  - States: IDLE, ACCESS, LD_CAP, SWP_WR, ABORT. req_ready_out = (state==IDLE).
//  - T0 accept: latch op/addr/wdata/tag. Misaligned (half addr[0]=1, word/SWP addr[1:0]!=0) or
//    op>9 -> ABORT; else -> ACCESS.
//  - ACCESS (T1): mem_addr=latched addr. Stores: we STR 1111, STRH 0011, STRB 0001, str_sel per op,
//    -> IDLE with st_done_out=1 in T2. Loads/swaps: we=0, load_sel per op (SWP 0, SWPB 3) -> LD_CAP.
//  - LD_CAP (T2): mem_rd_in sampled at end of cycle into rsp_rdata. Loads -> IDLE, rsp_valid_out=1
//    in T3. Swaps -> SWP_WR.
//  - SWP_WR (T3): mem_wd=latched wdata; SWP: mem_swp_ctrl_out=1, we=1111, str_sel 0; SWPB:
//    swp_ctrl=0, we=0001, str_sel 3 (never clobber upper lanes). -> IDLE, rsp_valid_out=1 in T4
//    carrying old value captured in LD_CAP.
//  - ABORT (T1): abort_out=1, we=0, no rsp_valid/st_done -> IDLE.
//  - Latency: store 2, load 3, swap 4 cycles accept-to-pulse; new request acceptable in the same
//    cycle as the previous pulse (back-to-back).
//  - mem_we_out and mem_swp_ctrl_out decode from state combinationally; 0 outside ACCESS(store)/SWP_WR.
//  - Reset (any time, incl. mid-swap): state IDLE, all outputs and latches 0 (ready=1); a write
//    in progress is dropped, no partial SWP completes, no pulses emitted.
//  - req_* ignored while not ready; pulses are mutually exclusive.
// STRUCTURE
//  - Op codes, load/store select codes and state encodings are defined in
//    load_store_memory_stage_define.v; this block includes it.
//  - One sub-module: mem_access_decode (combinational: op,addr[1:0] -> we mask, load_sel, str_sel,
//    is_load/is_store/is_swap, misalign).
// TESTING
//  - STR addr 0x100 data 0xDEADBEEF -> T1 we=1111 str_sel=0; T2 st_done; LDR 0x100 -> rsp 0xDEADBEEF in T3.
//  - STRB 0x104 data 0x80; LDRSB 0x104 -> rsp 0xFFFFFF80, load_sel=4; LDRB -> 0x00000080.
//  - Mem 0x108=0x11112222; SWP 0x108 data 0xCAFEF00D tag 5 -> rsp 0x11112222 tag 5 at T4, swp_ctrl=1
//    only in T3, then LDR 0x108 -> 0xCAFEF00D.
//  - LDRH 0x10B, LDR 0x102, op 0xC -> abort_out in T1, we=0 all cycles, no rsp_valid.
//  - reset_in pulsed during SWP_WR -> no write (LDR returns old value), no rsp_valid, ready=1 at once.
//  - Back-to-back LDR/STR stream with req_valid held high -> ready only in IDLE, one pulse per request.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared op codes, mux-select codes, lane masks and state encoding for the
// memory-stage data memory controller.
package data_mem_ctrl_pkg;

   localparam logic [3:0] OP_LDR   = 4'd0;
   localparam logic [3:0] OP_LDRH  = 4'd1;
   localparam logic [3:0] OP_LDRSH = 4'd2;
   localparam logic [3:0] OP_LDRB  = 4'd3;
   localparam logic [3:0] OP_LDRSB = 4'd4;
   localparam logic [3:0] OP_STR   = 4'd5;
   localparam logic [3:0] OP_STRH  = 4'd6;
   localparam logic [3:0] OP_STRB  = 4'd7;
   localparam logic [3:0] OP_SWP   = 4'd8;
   localparam logic [3:0] OP_SWPB  = 4'd9;

   localparam logic [2:0] SEL_WORD  = 3'd0;
   localparam logic [2:0] SEL_ZHALF = 3'd1;
   localparam logic [2:0] SEL_SHALF = 3'd2;
   localparam logic [2:0] SEL_ZBYTE = 3'd3;
   localparam logic [2:0] SEL_SBYTE = 3'd4;

   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam logic [3:0] WE_WORD = 4'b1111;
   localparam logic [3:0] WE_HALF = 4'b0011;
   localparam logic [3:0] WE_BYTE = 4'b0001;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_LD_CAP = 3'd2,
      ST_SWP_WR = 3'd3,
      ST_ABORT  = 3'd4
   } state_t;

endpackage

// File: rtl/data_mem_ctrl_mem_access_decode.sv
// Combinational decode of a memory-stage op and the low address bits into the
// write-lane mask, load/store mux selects, op class and misalignment flag.
module mem_access_decode
   import data_mem_ctrl_pkg::*;
(
   input  logic [3:0] op,
   input  logic [1:0] addr_lo,
   output logic [3:0] we_mask,
   output logic [2:0] load_sel,
   output logic [2:0] str_sel,
   output logic       is_load,
   output logic       is_store,
   output logic       is_swap,
   output logic       misalign
);

   logic word_mis_s;
   logic half_mis_s;

   assign word_mis_s = (addr_lo != 2'b00);
   assign half_mis_s = addr_lo[0];

   // Op decode; for swaps we_mask/str_sel describe the write-back half of the pair.
   always_comb begin
      we_mask  = WE_NONE;
      load_sel = SEL_WORD;
      str_sel  = SEL_WORD;
      is_load  = 1'b0;
      is_store = 1'b0;
      is_swap  = 1'b0;
      misalign = 1'b0;
      case (op)
         OP_LDR:   begin is_load = 1'b1; misalign = word_mis_s; end
         OP_LDRH:  begin is_load = 1'b1; load_sel = SEL_ZHALF; misalign = half_mis_s; end
         OP_LDRSH: begin is_load = 1'b1; load_sel = SEL_SHALF; misalign = half_mis_s; end
         OP_LDRB:  begin is_load = 1'b1; load_sel = SEL_ZBYTE; end
         OP_LDRSB: begin is_load = 1'b1; load_sel = SEL_SBYTE; end
         OP_STR:   begin is_store = 1'b1; we_mask = WE_WORD; misalign = word_mis_s; end
         OP_STRH:  begin is_store = 1'b1; we_mask = WE_HALF; str_sel = SEL_ZHALF; misalign = half_mis_s; end
         OP_STRB:  begin is_store = 1'b1; we_mask = WE_BYTE; str_sel = SEL_ZBYTE; end
         OP_SWP:   begin is_swap = 1'b1; we_mask = WE_WORD; misalign = word_mis_s; end
         OP_SWPB:  begin is_swap = 1'b1; we_mask = WE_BYTE; load_sel = SEL_ZBYTE; str_sel = SEL_ZBYTE; end
         default:  begin is_load = 1'b0; end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage sequencer in front of data_memory: one request in flight, alignment
// checking, atomic read-then-write swaps, tagged read responses and pipeline stall.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             req_valid_in,
   output logic             req_ready_out,
   input  logic [3:0]       req_op_in,
   input  logic [31:0]      req_addr_in,
   input  logic [31:0]      req_wdata_in,
   input  logic [TAG_W-1:0] req_tag_in,
   output logic [31:0]      mem_addr_out,
   output logic [3:0]       mem_we_out,
   output logic [31:0]      mem_wd_out,
   output logic             mem_swp_ctrl_out,
   output logic [2:0]       mem_load_sel_out,
   output logic [2:0]       mem_str_sel_out,
   input  logic [31:0]      mem_rd_in,
   output logic             rsp_valid_out,
   output logic [31:0]      rsp_rdata_out,
   output logic [TAG_W-1:0] rsp_tag_out,
   output logic             st_done_out,
   output logic             abort_out,
   output logic             stall_out
);

   state_t           state_r;
   logic [31:0]      addr_r;
   logic [31:0]      wdata_r;
   logic [31:0]      rdata_r;
   logic [TAG_W-1:0] tag_r;
   logic [3:0]       we_r;
   logic [2:0]       load_sel_r;
   logic [2:0]       str_sel_r;
   logic             is_store_r;
   logic             is_swap_r;
   logic             swp_word_r;
   logic             rsp_valid_r;
   logic             st_done_r;
   logic             abort_r;

   logic [3:0]       dec_we_s;
   logic [2:0]       dec_load_sel_s;
   logic [2:0]       dec_str_sel_s;
   logic             dec_is_load_s;
   logic             dec_is_store_s;
   logic             dec_is_swap_s;
   logic             dec_misalign_s;
   logic             accept_s;
   logic             reject_s;

   mem_access_decode u_decode (
      .op       (req_op_in),
      .addr_lo  (req_addr_in[1:0]),
      .we_mask  (dec_we_s),
      .load_sel (dec_load_sel_s),
      .str_sel  (dec_str_sel_s),
      .is_load  (dec_is_load_s),
      .is_store (dec_is_store_s),
      .is_swap  (dec_is_swap_s),
      .misalign (dec_misalign_s)
   );

   assign accept_s = req_valid_in && (state_r == ST_IDLE);
   assign reject_s = dec_misalign_s || !(dec_is_load_s || dec_is_store_s || dec_is_swap_s);

   // Request sequencing, operand latches and the three completion pulses.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_r     <= ST_IDLE;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         rdata_r     <= 32'd0;
         tag_r       <= '0;
         we_r        <= 4'd0;
         load_sel_r  <= 3'd0;
         str_sel_r   <= 3'd0;
         is_store_r  <= 1'b0;
         is_swap_r   <= 1'b0;
         swp_word_r  <= 1'b0;
         rsp_valid_r <= 1'b0;
         st_done_r   <= 1'b0;
         abort_r     <= 1'b0;
      end else begin
         rsp_valid_r <= 1'b0;
         st_done_r   <= 1'b0;
         abort_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  addr_r     <= req_addr_in;
                  wdata_r    <= req_wdata_in;
                  tag_r      <= req_tag_in;
                  we_r       <= dec_we_s;
                  load_sel_r <= dec_load_sel_s;
                  str_sel_r  <= dec_str_sel_s;
                  is_store_r <= dec_is_store_s;
                  is_swap_r  <= dec_is_swap_s;
                  swp_word_r <= (req_op_in == OP_SWP);
                  if (reject_s) begin
                     state_r <= ST_ABORT;
                     abort_r <= 1'b1;
                  end else begin
                     state_r <= ST_ACCESS;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (is_store_r) begin
                  state_r   <= ST_IDLE;
                  st_done_r <= 1'b1;
               end else begin
                  state_r <= ST_LD_CAP;
               end
            end
            ST_LD_CAP: begin
               rdata_r <= mem_rd_in;
               if (is_swap_r) begin
                  state_r <= ST_SWP_WR;
               end else begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b1;
               end
            end
            ST_SWP_WR: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b1;
            end
            ST_ABORT: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Lanes open only in a store's access cycle or a swap's write-back cycle, so a
   // reset that forces IDLE also closes them immediately.
   always_comb begin
      if (((state_r == ST_ACCESS) && is_store_r) || (state_r == ST_SWP_WR)) begin
         mem_we_out = we_r;
      end else begin
         mem_we_out = WE_NONE;
      end
      if (state_r == ST_SWP_WR) begin
         mem_swp_ctrl_out = swp_word_r;
      end else begin
         mem_swp_ctrl_out = 1'b0;
      end
   end

   assign req_ready_out    = (state_r == ST_IDLE);
   assign stall_out        = (state_r != ST_IDLE);
   assign mem_addr_out     = addr_r;
   assign mem_wd_out       = wdata_r;
   assign mem_load_sel_out = load_sel_r;
   assign mem_str_sel_out  = str_sel_r;
   assign rsp_valid_out    = rsp_valid_r;
   assign rsp_rdata_out    = rdata_r;
   assign rsp_tag_out      = tag_r;
   assign st_done_out      = st_done_r;
   assign abort_out        = abort_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed, table-driven bench for data_mem_ctrl with a small byte-addressed
// data_memory model that applies lane enables and load extension.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   localparam logic [2:0] P_RSP = 3'b100;
   localparam logic [2:0] P_ST  = 3'b010;
   localparam logic [2:0] P_AB  = 3'b001;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        req_valid_in;
   logic        req_ready_out;
   logic [3:0]  req_op_in;
   logic [31:0] req_addr_in;
   logic [31:0] req_wdata_in;
   logic [3:0]  req_tag_in;
   logic [31:0] mem_addr_out;
   logic [3:0]  mem_we_out;
   logic [31:0] mem_wd_out;
   logic        mem_swp_ctrl_out;
   logic [2:0]  mem_load_sel_out;
   logic [2:0]  mem_str_sel_out;
   logic [31:0] mem_rd_in = 32'd0;
   logic        rsp_valid_out;
   logic [31:0] rsp_rdata_out;
   logic [3:0]  rsp_tag_out;
   logic        st_done_out;
   logic        abort_out;
   logic        stall_out;

   int errors = 0;
   int checks = 0;

   data_mem_ctrl #(.TAG_W(4)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_op_in(req_op_in), .req_addr_in(req_addr_in),
      .req_wdata_in(req_wdata_in), .req_tag_in(req_tag_in),
      .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
      .mem_wd_out(mem_wd_out), .mem_swp_ctrl_out(mem_swp_ctrl_out),
      .mem_load_sel_out(mem_load_sel_out), .mem_str_sel_out(mem_str_sel_out),
      .mem_rd_in(mem_rd_in),
      .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out),
      .rsp_tag_out(rsp_tag_out), .st_done_out(st_done_out),
      .abort_out(abort_out), .stall_out(stall_out)
   );

   always #5 clk_in = ~clk_in;

   // data_memory model: byte array, lanes relative to the address, registered read
   logic [7:0] mem [0:511];
   logic       mem_init_done = 1'b0;

   function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] sel);
      case (sel)
         3'd1:    return {16'h0000, w[15:0]};
         3'd2:    return {{16{w[15]}}, w[15:0]};
         3'd3:    return {24'h000000, w[7:0]};
         3'd4:    return {{24{w[7]}}, w[7:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] rd_word(input logic [8:0] a);
      return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
   endfunction

   always @(posedge clk_in) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            mem[9'h104 + 9'(i)] <= 8'(32'h55667700 >> (8 * i));
            mem[9'h108 + 9'(i)] <= 8'(32'h11112222 >> (8 * i));
            mem[9'h10C + 9'(i)] <= 8'(32'h77770000 >> (8 * i));
            mem[9'h110 + 9'(i)] <= 8'(32'h44332211 >> (8 * i));
         end
         mem_init_done <= 1'b1;
      end else begin
         mem_rd_in <= ld_ext(rd_word(mem_addr_out[8:0]), mem_load_sel_out);
         for (int i = 0; i < 4; i++) begin
            if (mem_we_out[i] || mem_swp_ctrl_out)
               mem[mem_addr_out[8:0] + 9'(i)] <= mem_wd_out[8*i +: 8];
         end
      end
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  tag;
      logic [2:0]  pulse;
      int          lat;
      logic [31:0] rdata;
      int          we_cyc;
      logic [3:0]  we;
      int          swp_cyc;
      logic [2:0]  lsel;
      logic [2:0]  ssel;
   } vec_t;

   vec_t vt [0:24];

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] tag, input logic [2:0] pulse, input int lat,
                               input logic [31:0] rdata, input int we_cyc, input logic [3:0] we,
                               input int swp_cyc, input logic [2:0] lsel, input logic [2:0] ssel);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.tag = tag; v.pulse = pulse; v.lat = lat;
      v.rdata = rdata; v.we_cyc = we_cyc; v.we = we; v.swp_cyc = swp_cyc; v.lsel = lsel; v.ssel = ssel;
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] tag);
      req_op_in = op; req_addr_in = addr; req_wdata_in = wdata; req_tag_in = tag;
   endtask

   // Issue one request in the current (idle) cycle and follow it to its pulse.
   task automatic run_vec(input vec_t v, input int n);
      int          pulse_cyc = 0;
      int          we_cyc = 0;
      int          swp_cyc = 0;
      logic [3:0]  we_seen = 4'd0;
      logic [2:0]  pulse = 3'd0;
      logic [2:0]  lsel1 = 3'd0;
      logic [2:0]  ssel_w = 3'd0;
      logic [31:0] rd = 32'd0;
      logic [3:0]  tg = 4'd0;
      logic        busy_bad = 1'b0;
      logic [2:0]  p;
      set_req(v.op, v.addr, v.wdata, v.tag);
      req_valid_in = 1'b1;
      for (int c = 1; c <= 6 && pulse_cyc == 0; c++) begin
         @(posedge clk_in); #1;
         if (c == 1) begin
            req_valid_in = 1'b0;
            lsel1 = mem_load_sel_out;
         end
         if (mem_we_out != 4'd0) begin
            we_cyc  = (we_cyc == 0) ? c : 99;
            we_seen = mem_we_out;
            ssel_w  = mem_str_sel_out;
         end
         if (mem_swp_ctrl_out) swp_cyc = (swp_cyc == 0) ? c : 99;
         if (req_ready_out == stall_out) busy_bad = 1'b1;
         p = {rsp_valid_out, st_done_out, abort_out};
         if (p != 3'd0) begin
            pulse_cyc = c;
            pulse = p;
            rd = rsp_rdata_out;
            tg = rsp_tag_out;
            if (p != P_AB && !req_ready_out) busy_bad = 1'b1;
         end else if (req_ready_out) begin
            busy_bad = 1'b1;
         end
      end
      check($sformatf("v%0d_pulse", n), pulse, v.pulse);
      check($sformatf("v%0d_latency", n), pulse_cyc, v.lat);
      check($sformatf("v%0d_we_cycle", n), we_cyc, v.we_cyc);
      check($sformatf("v%0d_we_mask", n), we_seen, v.we);
      check($sformatf("v%0d_swp_cycle", n), swp_cyc, v.swp_cyc);
      check($sformatf("v%0d_ready_stall", n), busy_bad, 1'b0);
      if (v.pulse == P_RSP) begin
         check($sformatf("v%0d_rdata", n), rd, v.rdata);
         check($sformatf("v%0d_tag", n), tg, v.tag);
         check($sformatf("v%0d_load_sel", n), lsel1, v.lsel);
      end
      if (v.we_cyc != 0) check($sformatf("v%0d_str_sel", n), ssel_w, v.ssel);
      if (v.pulse == P_AB) begin
         @(posedge clk_in); #1;
         check($sformatf("v%0d_idle_after_abort", n), req_ready_out, 1'b1);
      end
   endtask

   // req_valid held high: new fields only at pulse cycles, junk while busy.
   task automatic run_stream();
      int          np = 0;
      int          cyc_log [4];
      logic [2:0]  p_log [4];
      logic [31:0] d_log [4];
      logic [2:0]  p;
      logic        bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc_log[k] = 0; p_log[k] = 3'd0; d_log[k] = 32'd0;
      end
      set_req(OP_STR, 32'h120, 32'h01020304, 4'd0);
      req_valid_in = 1'b1;
      for (int c = 1; c <= 14 && np < 4; c++) begin
         @(posedge clk_in); #1;
         if (req_ready_out == stall_out) bad = 1'b1;
         p = {rsp_valid_out, st_done_out, abort_out};
         if (p != 3'd0) begin
            if (!req_ready_out) bad = 1'b1;
            p_log[np] = p; cyc_log[np] = c; d_log[np] = rsp_rdata_out;
            np++;
            case (np)
               1:       set_req(OP_LDR, 32'h120, 32'h0, 4'd8);
               2:       set_req(OP_STR, 32'h124, 32'hA5A5A5A5, 4'd0);
               3:       set_req(OP_LDR, 32'h124, 32'h0, 4'd9);
               default: req_valid_in = 1'b0;
            endcase
         end else begin
            if (req_ready_out) bad = 1'b1;
            set_req(OP_SWP, 32'h100, 32'hFFFFFFFF, 4'hF);
         end
      end
      req_valid_in = 1'b0;
      check("stream_count", np, 4);
      check("stream_ready", bad, 1'b0);
      check("stream_pulses", {p_log[0], p_log[1], p_log[2], p_log[3]}, {P_ST, P_RSP, P_ST, P_RSP});
      check("stream_cycles", {cyc_log[0], cyc_log[1], cyc_log[2], cyc_log[3]}, {32'd2, 32'd5, 32'd7, 32'd10});
      check("stream_rdata", {d_log[1], d_log[3]}, {32'h01020304, 32'hA5A5A5A5});
   endtask

   initial begin
      logic [127:0] rst_exp;
      logic [2:0]   pulses_seen;
      reset_in = 1'b1;
      req_valid_in = 1'b0;
      set_req(4'd0, 32'd0, 32'd0, 4'd0);

      vt[0]  = mk(OP_STR,   32'h100, 32'hDEADBEEF, 4'd1, P_ST,  2, 32'h0,        1, 4'hF, 0, 3'd0, 3'd0);
      vt[1]  = mk(OP_LDR,   32'h100, 32'h0,        4'd2, P_RSP, 3, 32'hDEADBEEF, 0, 4'h0, 0, 3'd0, 3'd0);
      vt[2]  = mk(OP_STRB,  32'h104, 32'h12345680, 4'd0, P_ST,  2, 32'h0,        1, 4'h1, 0, 3'd0, 3'd3);
      vt[3]  = mk(OP_LDRSB, 32'h104, 32'h0,        4'd3, P_RSP, 3, 32'hFFFFFF80, 0, 4'h0, 0, 3'd4, 3'd0);
      vt[4]  = mk(OP_LDRB,  32'h104, 32'h0,        4'd4, P_RSP, 3, 32'h00000080, 0, 4'h0, 0, 3'd3, 3'd0);
      vt[5]  = mk(OP_LDR,   32'h104, 32'h0,        4'd5, P_RSP, 3, 32'h55667780, 0, 4'h0, 0, 3'd0, 3'd0);
      vt[6]  = mk(OP_STRH,  32'h10C, 32'hFFFF8001, 4'd0, P_ST,  2, 32'h0,        1, 4'h3, 0, 3'd0, 3'd1);
      vt[7]  = mk(OP_LDRSH, 32'h10C, 32'h0,        4'd6, P_RSP, 3, 32'hFFFF8001, 0, 4'h0, 0, 3'd2, 3'd0);
      vt[8]  = mk(OP_LDRH,  32'h10C, 32'h0,        4'd7, P_RSP, 3, 32'h00008001, 0, 4'h0, 0, 3'd1, 3'd0);
      vt[9]  = mk(OP_LDR,   32'h10C, 32'h0,        4'd8, P_RSP, 3, 32'h77778001, 0, 4'h0, 0, 3'd0, 3'd0);
      vt[10] = mk(OP_SWP,   32'h108, 32'hCAFEF00D, 4'd5, P_RSP, 4, 32'h11112222, 3, 4'hF, 3, 3'd0, 3'd0);
      vt[11] = mk(OP_LDR,   32'h108, 32'h0,        4'd9, P_RSP, 3, 32'hCAFEF00D, 0, 4'h0, 0, 3'd0, 3'd0);
      vt[12] = mk(OP_SWPB,  32'h110, 32'hFFFFFFAB, 4'd6, P_RSP, 4, 32'h00000011, 3, 4'h1, 0, 3'd3, 3'd3);
      vt[13] = mk(OP_LDR,   32'h110, 32'h0,        4'hA, P_RSP, 3, 32'h443322AB, 0, 4'h0, 0, 3'd0, 3'd0);
      vt[14] = mk(OP_LDRH,  32'h102, 32'h0,        4'hB, P_RSP, 3, 32'h0000DEAD, 0, 4'h0, 0, 3'd1, 3'd0);
      vt[15] = mk(OP_LDRSH, 32'h102, 32'h0,        4'hC, P_RSP, 3, 32'hFFFFDEAD, 0, 4'h0, 0, 3'd2, 3'd0);
      vt[16] = mk(OP_LDRH,  32'h10B, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);
      vt[17] = mk(OP_LDR,   32'h102, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);
      vt[18] = mk(4'hC,     32'h100, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);
      vt[19] = mk(OP_STR,   32'h101, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);
      vt[20] = mk(OP_SWP,   32'h10A, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);
      vt[21] = mk(OP_STRH,  32'h105, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);
      vt[22] = mk(OP_LDR,   32'h100, 32'h0,        4'hD, P_RSP, 3, 32'hDEADBEEF, 0, 4'h0, 0, 3'd0, 3'd0);
      vt[23] = mk(OP_LDRB,  32'h107, 32'h0,        4'hE, P_RSP, 3, 32'h00000055, 0, 4'h0, 0, 3'd3, 3'd0);
      vt[24] = mk(4'hF,     32'h100, 32'h0,        4'd1, P_AB,  1, 32'h0,        0, 4'h0, 0, 3'd0, 3'd0);

      repeat (3) @(posedge clk_in);
      #1;
      rst_exp = 128'd0;
      rst_exp[127] = 1'b1;
      check("reset_state",
            {req_ready_out, stall_out, mem_we_out, mem_swp_ctrl_out, rsp_valid_out, st_done_out,
             abort_out, mem_addr_out, rsp_rdata_out, rsp_tag_out, mem_load_sel_out, mem_str_sel_out,
             mem_wd_out, 12'd0},
            rst_exp);
      reset_in = 1'b0;

      for (int i = 0; i < 25; i++) run_vec(vt[i], i);

      run_stream();
      run_vec(mk(OP_LDR, 32'h100, 32'h0, 4'd3, P_RSP, 3, 32'hDEADBEEF, 0, 4'h0, 0, 3'd0, 3'd0), 100);

      // reset in the middle of a swap's write-back cycle
      set_req(OP_SWP, 32'h108, 32'h99999999, 4'd7);
      req_valid_in = 1'b1;
      @(posedge clk_in); #1;
      req_valid_in = 1'b0;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      check("rst_swp_ctrl_before", mem_swp_ctrl_out, 1'b1);
      reset_in = 1'b1;
      #1;
      check("rst_async", {req_ready_out, stall_out, mem_we_out, mem_swp_ctrl_out}, {1'b1, 1'b0, 4'h0, 1'b0});
      @(posedge clk_in); #1;
      reset_in = 1'b0;
      check("rst_rdata_cleared", rsp_rdata_out, 32'd0);
      pulses_seen = 3'd0;
      for (int c = 0; c < 4; c++) begin
         pulses_seen = pulses_seen | {rsp_valid_out, st_done_out, abort_out};
         @(posedge clk_in); #1;
      end
      check("rst_no_pulse", pulses_seen, 3'd0);
      run_vec(mk(OP_LDR, 32'h108, 32'h0, 4'd4, P_RSP, 3, 32'hCAFEF00D, 0, 4'h0, 0, 3'd0, 3'd0), 101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
